// File: rtl/piso_pkg.sv
// Shared constants, parity encodings, state type and frame-length helper for piso_reg.
package piso_pkg;

  localparam int FRAME_W = 11;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Start + data + optional parity + stop bits; always 9..12.
  function automatic logic [3:0] frame_len(input logic [1:0] parity_type,
                                           input logic       data_length,
                                           input logic       stop_bits);
    logic [3:0] len;
    len = data_length ? 4'd9 : 4'd8;
    if (parity_type == PAR_ODD || parity_type == PAR_EVEN) len = len + 4'd1;
    len = len + (stop_bits ? 4'd2 : 4'd1);
    return len;
  endfunction

endpackage

// File: rtl/piso_parity_gen.sv
// Combinational parity over the 7 or 8 data bits of a frame, selected by parity_type.
module piso_parity_gen
  import piso_pkg::*;
(
  input  logic [7:0] data,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  output logic       parity
);

  logic raw;

  always_comb begin
    raw = data_length ? ^data : ^data[6:0];
    case (parity_type)
      PAR_ODD:  parity = ~raw;
      PAR_EVEN: parity = raw;
      default:  parity = 1'b0;
    endcase
  end

endmodule

// File: rtl/piso_reg.sv
// UART-Tx parallel-in/serial-out shift register, LSB first, one bit per BaudOut edge.
// Macro PISO_PARITY_OUT_EN enables the registered p_parity_out; otherwise it is tied low.
//
// state | meaning
// IDLE  | line idles at 1, waiting for send
// SHIFT | driving latched frame bit[cnt] each edge until cnt reaches the frame length
module piso_reg
  import piso_pkg::*;
(
  input  logic               BaudOut,
  input  logic               rst,
  input  logic               send,
  input  logic [FRAME_W-1:0] FrameOut,
  input  logic [1:0]         parity_type,
  input  logic               data_length,
  input  logic               stop_bits,
  output logic               data_out,
  output logic               p_parity_out,
  output logic               tx_active,
  output logic               tx_done
);

  state_t             state;
  logic [FRAME_W-1:0] frame_q;
  logic [3:0]         len_q;
  logic [3:0]         cnt;
  logic [15:0]        frame_ext;
  logic               load;

  // Positions past the captured frame (second stop bit of 8-data+parity) read as 1.
  assign frame_ext = {{(16 - FRAME_W){1'b1}}, frame_q};

  // A new frame starts from IDLE or on the edge right after the last bit.
  assign load = send && ((state == IDLE) || (cnt == len_q));

  always_ff @(posedge BaudOut or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      frame_q   <= '1;
      len_q     <= 4'd0;
      cnt       <= 4'd0;
      data_out  <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else if (load) begin
      state     <= SHIFT;
      frame_q   <= FrameOut;
      len_q     <= frame_len(parity_type, data_length, stop_bits);
      cnt       <= 4'd1;
      data_out  <= FrameOut[0];
      tx_active <= 1'b1;
      tx_done   <= 1'b0;
    end else if (state == SHIFT) begin
      if (cnt == len_q) begin
        state     <= IDLE;
        cnt       <= 4'd0;
        data_out  <= 1'b1;
        tx_active <= 1'b0;
        tx_done   <= 1'b0;
      end else begin
        cnt      <= cnt + 4'd1;
        data_out <= frame_ext[cnt];
        tx_done  <= (cnt == len_q - 4'd1);
      end
    end
  end

`ifdef PISO_PARITY_OUT_EN
  logic par_next;
  logic par_q;

  piso_parity_gen u_parity (
    .data        (FrameOut[8:1]),
    .data_length (data_length),
    .parity_type (parity_type),
    .parity      (par_next)
  );

  always_ff @(posedge BaudOut or negedge rst) begin
    if (!rst)      par_q <= 1'b0;
    else if (load) par_q <= par_next;
  end

  assign p_parity_out = par_q;
`else
  assign p_parity_out = 1'b0;
`endif

endmodule

// File: tb/tb_piso_reg.sv
// Scoreboard bench for piso_reg: stimulus queues expected per-cycle outputs, a negedge monitor checks them.
module tb_piso_reg;

  logic        BaudOut = 1'b0;
  logic        rst = 1'b0;
  logic        send = 1'b0;
  logic [10:0] FrameOut = '0;
  logic [1:0]  parity_type = '0;
  logic        data_length = 1'b0;
  logic        stop_bits = 1'b0;
  logic        data_out, p_parity_out, tx_active, tx_done;

  typedef struct packed {
    logic d;
    logic a;
    logic dn;
    logic p;
  } exp_t;

  exp_t  sb[$];
  string names[$];
  int    errors = 0;
  int    checks = 0;
  logic  cur_par = 1'b0;

  piso_reg dut (
    .BaudOut      (BaudOut),
    .rst          (rst),
    .send         (send),
    .FrameOut     (FrameOut),
    .parity_type  (parity_type),
    .data_length  (data_length),
    .stop_bits    (stop_bits),
    .data_out     (data_out),
    .p_parity_out (p_parity_out),
    .tx_active    (tx_active),
    .tx_done      (tx_done)
  );

  always #10 BaudOut = ~BaudOut;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (d/active/done/par nibble)", nm, act, req);
    end
  endtask

  always @(negedge BaudOut) begin
    if (sb.size() != 0) begin
      exp_t  e;
      string nm;
      e  = sb.pop_front();
      nm = names.pop_front();
      check(nm, int'({data_out, tx_active, tx_done, p_parity_out}), int'(e));
    end
  end

  function automatic logic pe(input logic p);
`ifdef PISO_PARITY_OUT_EN
    return p;
`else
    return 1'b0 & p;
`endif
  endfunction

  task automatic step(input string nm, input logic d, input logic a, input logic dn, input logic p);
    sb.push_back('{d: d, a: a, dn: dn, p: p});
    names.push_back(nm);
    @(posedge BaudOut);
    @(negedge BaudOut);
    #1;
  endtask

  // cfg = {stop_bits, data_length, parity_type}; inputs are scrambled after the load edge.
  task automatic run_frame(input string nm, input logic [10:0] fr, input logic [3:0] cfg,
                           input int len, input logic par, input int nbits);
    logic [15:0] ext;
    ext = {5'h1f, fr};
    cur_par = pe(par);
    send = 1'b1;
    FrameOut = fr;
    {stop_bits, data_length, parity_type} = cfg;
    step($sformatf("%s bit0", nm), ext[0], 1'b1, 1'b0, cur_par);
    for (int i = 1; i < nbits; i++) begin
      send = 1'($urandom_range(0, 1));
      FrameOut = 11'($urandom);
      {stop_bits, data_length, parity_type} = 4'($urandom);
      step($sformatf("%s bit%0d", nm, i), ext[i], 1'b1, (i == len - 1), cur_par);
    end
    send = 1'b0;
  endtask

  task automatic idle_step(input string nm);
    send = 1'b0;
    step(nm, 1'b1, 1'b0, 1'b0, cur_par);
  endtask

  initial begin
    repeat (3) step("reset hold", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle_step("idle after reset");
    idle_step("idle after reset");

    run_frame("8N1", 11'b11010010100, 4'b0100, 10, 1'b0, 10);
    idle_step("idle after 8N1");

    run_frame("8O1", 11'b10010010100, 4'b0101, 11, 1'b0, 11);
    run_frame("7E2 b2b", 11'b11010010100, 4'b1010, 11, 1'b1, 11);
    run_frame("8E2 b2b", 11'b11101101010, 4'b1110, 12, 1'b1, 12);
    run_frame("7N1 b2b", 11'b11110110110, 4'b0011, 9, 1'b0, 9);
    idle_step("idle after 7N1");
    idle_step("idle held parity");

    run_frame("8O1 aborted", 11'b10010010100, 4'b0101, 11, 1'b0, 4);
    rst = 1'b0;
    #1;
    check("reset mid-frame immediate", int'({data_out, tx_active, tx_done, p_parity_out}), 8);
    cur_par = 1'b0;
    step("reset mid-frame hold", 1'b1, 1'b0, 1'b0, 1'b0);
    step("reset mid-frame hold", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    run_frame("8E2 after reset", 11'b11101101010, 4'b1110, 12, 1'b1, 12);
    idle_step("final idle");

    repeat (2) @(negedge BaudOut);
    check("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench did not terminate");
  end

endmodule
